// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings,
// ready/start level names and the operand width.
package div_unit_pkg;

    localparam int DivDataW = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } divState_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: trial subtract of the (W+1)-bit shifted partial
// remainder minus the zero-extended divisor. o_borrow is set when the divisor does
// not fit; o_diff is the low W bits of the difference, which is all that survives
// because a successful subtract always leaves a value smaller than the divisor.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   i_minuend,
    input  logic [W:0]   i_subtrahend,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    // Borrow out of the full-width subtract and the retained low bits.
    always_comb begin
        o_borrow = (i_minuend < i_subtrahend);
        o_diff   = i_minuend[W-1:0] - i_subtrahend[W-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}; ready_o is high only in the END state and
// stays there until the requester drops start_i.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DivDataW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] LastCount = CntW'(DATA_W);

    divState_e             r_state,    w_stateNext;
    logic [CntW-1:0]       r_count,    w_countNext;
    logic [DATA_W-1:0]     r_rem,      w_remNext;
    logic [DATA_W-1:0]     r_quot,     w_quotNext;
    logic [DATA_W-1:0]     r_divisor,  w_divisorNext;
    logic                  r_signed,   w_signedNext;
    logic                  r_negA,     w_negANext;
    logic                  r_negB,     w_negBNext;
    logic [2*DATA_W-1:0]   r_result,   w_resultNext;
    logic                  r_ready,    w_readyNext;

    logic [DATA_W:0]       w_shifted;
    logic [DATA_W-1:0]     w_diff;
    logic                  w_borrow;
    logic [DATA_W-1:0]     w_stepRem;
    logic [DATA_W-1:0]     w_stepQuot;
    logic [DATA_W-1:0]     w_absA;
    logic [DATA_W-1:0]     w_absB;
    logic [DATA_W-1:0]     w_fixQuot;
    logic [DATA_W-1:0]     w_fixRem;

    // {rem,quot} shifted left by one; the quotient register doubles as the
    // dividend shift source, so its MSB feeds the partial remainder.
    assign w_shifted = {r_rem, r_quot[DATA_W-1]};

    div_step #(.W(DATA_W)) u_step (
        .i_minuend    (w_shifted),
        .i_subtrahend ({1'b0, r_divisor}),
        .o_diff       (w_diff),
        .o_borrow     (w_borrow)
    );

    // Step result, operand magnitudes and final sign correction.
    always_comb begin
        w_stepRem  = w_borrow ? w_shifted[DATA_W-1:0] : w_diff;
        w_stepQuot = {r_quot[DATA_W-2:0], ~w_borrow};
        w_absA     = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        w_absB     = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        w_fixQuot  = (r_signed && (r_negA ^ r_negB)) ? -r_quot : r_quot;
        w_fixRem   = (r_signed && r_negA) ? -r_rem : r_rem;
    end

    // Next-state and datapath update; every register holds unless a state acts on it.
    always_comb begin
        w_stateNext   = r_state;
        w_countNext   = r_count;
        w_remNext     = r_rem;
        w_quotNext    = r_quot;
        w_divisorNext = r_divisor;
        w_signedNext  = r_signed;
        w_negANext    = r_negA;
        w_negBNext    = r_negB;
        w_resultNext  = r_result;
        w_readyNext   = r_ready;

        case (r_state)
            DivFree: begin
                w_resultNext = '0;
                w_readyNext  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_stateNext = DivByZero;
                    end else begin
                        w_stateNext   = DivOn;
                        w_countNext   = '0;
                        w_remNext     = '0;
                        w_quotNext    = w_absA;
                        w_divisorNext = w_absB;
                        w_signedNext  = signed_div_i;
                        w_negANext    = opdata1_i[DATA_W-1];
                        w_negBNext    = opdata2_i[DATA_W-1];
                    end
                end
            end

            DivByZero: begin
                w_stateNext  = DivEnd;
                w_resultNext = '0;
                w_readyNext  = DivResultReady;
            end

            DivOn: begin
                if (annul_i) begin
                    w_stateNext  = DivFree;
                    w_resultNext = '0;
                    w_readyNext  = DivResultNotReady;
                end else if (r_count == LastCount) begin
                    w_stateNext  = DivEnd;
                    w_resultNext = {w_fixRem, w_fixQuot};
                    w_readyNext  = DivResultReady;
                end else begin
                    w_remNext   = w_stepRem;
                    w_quotNext  = w_stepQuot;
                    w_countNext = r_count + 1'b1;
                end
            end

            DivEnd: begin
                if (start_i == DivStop) begin
                    w_stateNext  = DivFree;
                    w_resultNext = '0;
                    w_readyNext  = DivResultNotReady;
                end
            end

            default: begin
                w_stateNext  = DivFree;
                w_resultNext = '0;
                w_readyNext  = DivResultNotReady;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything, even mid-division.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DivFree;
            r_count   <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_signed  <= 1'b0;
            r_negA    <= 1'b0;
            r_negB    <= 1'b0;
            r_result  <= '0;
            r_ready   <= DivResultNotReady;
        end else begin
            r_state   <= w_stateNext;
            r_count   <= w_countNext;
            r_rem     <= w_remNext;
            r_quot    <= w_quotNext;
            r_divisor <= w_divisorNext;
            r_signed  <= w_signedNext;
            r_negA    <= w_negANext;
            r_negB    <= w_negBNext;
            r_result  <= w_resultNext;
            r_ready   <= w_readyNext;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
